// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared types and constants for the RC4 key-scheduling stage
package ksa_pkg;
    localparam int KSA_STEPS     = 256;
    localparam int KSA_ADDR_W    = 8;
    localparam int KSA_KEY_BYTES = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I,
        S_WAIT_I,
        S_CALC_J,
        S_RD_J,
        S_WAIT_J,
        S_WR_I,
        S_WR_J,
        S_INC,
        S_DONE
    } ksa_state_t;
endpackage

// File: rtl/ksa_key_sel.sv
// rtl/ksa_key_sel.sv - selects key byte k from the latched key, byte 0 being the MSB
module ksa_key_sel
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = KSA_KEY_BYTES,
    parameter int K_W       = 2
) (
    input  logic [8*KEY_BYTES-1:0] i_key,
    input  logic [K_W-1:0]         i_k,
    output logic [7:0]             o_byte
);
    always_comb begin
        o_byte = 8'd0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (i_k == K_W'(b)) begin
                o_byte = i_key[8*(KEY_BYTES-b)-1 -: 8];
            end
        end
    end
endmodule

// File: rtl/ksa_swap_fsm.sv
// rtl/ksa_swap_fsm.sv - RC4 key-scheduling swap loop over the S-array RAM
// Optional: KSA_SKIP_SELF_SWAP_EN skips the read/write half of iterations where j == i.
module ksa_swap_fsm
    import ksa_pkg::*;
#(
    parameter int KEY_BYTES = KSA_KEY_BYTES
) (
    input  logic                   clock,
    input  logic                   restart,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [7:0]             q,
    output logic [KSA_ADDR_W-1:0]  address,
    output logic [7:0]             data,
    output logic                   wren,
    output logic                   busy,
    output logic                   done
);
    localparam int                    K_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [K_W-1:0]        K_LAST = K_W'(KEY_BYTES - 1);
    localparam logic [KSA_ADDR_W-1:0] I_LAST = KSA_ADDR_W'(KSA_STEPS - 1);

    ksa_state_t             r_state;
    logic [KSA_ADDR_W-1:0]  r_i;
    logic [KSA_ADDR_W-1:0]  r_j;
    logic [K_W-1:0]         r_k;
    logic [7:0]             r_s_i;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [KSA_ADDR_W-1:0]  r_address;
    logic [7:0]             r_data;
    logic                   r_wren;
    logic                   r_busy;
    logic                   r_done;

    logic [7:0]             w_key_byte;
    logic [KSA_ADDR_W-1:0]  w_j_next;

    ksa_key_sel #(
        .KEY_BYTES (KEY_BYTES),
        .K_W       (K_W)
    ) u_key_sel (
        .i_key  (r_key),
        .i_k    (r_k),
        .o_byte (w_key_byte)
    );

    assign w_j_next = r_j + r_s_i + w_key_byte;

    // Outputs are registered with the state: each branch sets what the next state drives.
    // r_data carries s_j from WAIT_J straight into the WR_I cycle.
    always_ff @(posedge clock) begin
        if (!restart) begin
            r_state   <= S_IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_s_i     <= '0;
            r_key     <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_wren    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_address <= '0;
            r_data    <= '0;
            r_wren    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key   <= secret_key;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= S_RD_I;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_RD_I: begin
                    r_address <= r_i;
                    r_state   <= S_WAIT_I;
                end
                S_WAIT_I: begin
                    r_s_i   <= q;
                    r_state <= S_CALC_J;
                end
                S_CALC_J: begin
                    r_j <= w_j_next;
`ifdef KSA_SKIP_SELF_SWAP_EN
                    if (w_j_next == r_i) begin
                        r_state <= S_INC;
                    end else begin
                        r_address <= w_j_next;
                        r_state   <= S_RD_J;
                    end
`else
                    r_address <= w_j_next;
                    r_state   <= S_RD_J;
`endif
                end
                S_RD_J: begin
                    r_address <= r_j;
                    r_state   <= S_WAIT_J;
                end
                S_WAIT_J: begin
                    r_address <= r_i;
                    r_data    <= q;
                    r_wren    <= 1'b1;
                    r_state   <= S_WR_I;
                end
                S_WR_I: begin
                    r_address <= r_j;
                    r_data    <= r_s_i;
                    r_wren    <= 1'b1;
                    r_state   <= S_WR_J;
                end
                S_WR_J: begin
                    r_state <= S_INC;
                end
                S_INC: begin
                    if (r_i == I_LAST) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i       <= r_i + KSA_ADDR_W'(1);
                        r_k       <= (r_k == K_LAST) ? '0 : r_k + K_W'(1);
                        r_address <= r_i + KSA_ADDR_W'(1);
                        r_state   <= S_RD_I;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign address = r_address;
    assign data    = r_data;
    assign wren    = r_wren;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb/tb_ksa_swap_fsm.sv - self-checking bench for ksa_swap_fsm against a software RC4 KSA model
module tb_ksa_swap_fsm;
`ifdef KSA_SKIP_SELF_SWAP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        restart;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        busy;
    logic        done;

    always #5 clock = ~clock;

    ksa_swap_fsm #(.KEY_BYTES(3)) dut (
        .clock      (clock),
        .restart    (restart),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous-read RAM: address registered at the edge, data valid the following cycle.
    logic [7:0] mem [256];
    logic [7:0] ram_addr_q;
    logic       ram_init = 1'b0;

    always @(posedge clock) begin
        if (ram_init) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
        end else if (wren) begin
            mem[address] <= data;
        end
        ram_addr_q <= address;
    end
    assign q = mem[ram_addr_q];

    typedef struct {
        int cyc;
        bit wr;
        int addr;
        int data;
    } ev_t;

    ev_t        ev[$];
    int         ev_rd;
    int         exp_done;
    logic [7:0] exp_s [256];
    int         checks   = 0;
    int         failures = 0;
    int         cyc;
    int         done_cyc;
    bit         active = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Software KSA producing the expected RAM-port activity per cycle and the final S-array.
    task automatic build_model(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] kb;
        logic [7:0] t;
        int j;
        int c;
        ev.delete();
        for (int a = 0; a < 256; a++) s[a] = 8'(a);
        j = 0;
        c = 1;
        for (int i = 0; i < 256; i++) begin
            kb = key[8*(2-(i%3)) +: 8];
            j  = (j + int'(s[i]) + int'(kb)) % 256;
            ev.push_back('{c, 1'b0, i, 0});
            ev.push_back('{c + 2, 1'b0, 0, 0});
            if (SKIP && i == j) begin
                ev.push_back('{c + 3, 1'b0, 0, 0});
                c += 4;
            end else begin
                ev.push_back('{c + 3, 1'b0, j, 0});
                ev.push_back('{c + 5, 1'b1, i, int'(s[j])});
                ev.push_back('{c + 6, 1'b1, j, int'(s[i])});
                ev.push_back('{c + 7, 1'b0, 0, 0});
                c += 8;
            end
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        exp_done = c;
        for (int a = 0; a < 256; a++) exp_s[a] = s[a];
    endtask

    task automatic find_ev(input int c, output bit found, output ev_t e);
        found = 1'b0;
        e     = '{0, 1'b0, 0, 0};
        foreach (ev[n]) begin
            if (ev[n].cyc == c) begin
                found = 1'b1;
                e     = ev[n];
            end
        end
    endtask

    task automatic check_cycle();
        ev_t e;
        if (done) done_cyc = cyc;
        if (ev_rd < ev.size() && ev[ev_rd].cyc == cyc) begin
            e = ev[ev_rd];
            ev_rd++;
            chk("wren", int'(wren), int'(e.wr));
            chk("address", int'(address), e.addr);
            chk("data", int'(data), e.wr ? e.data : 0);
        end else begin
            chk("wren_quiet", int'(wren), 0);
            chk("data_quiet", int'(data), 0);
            if (cyc == exp_done) chk("address_done", int'(address), 0);
        end
        if (cyc <= exp_done) begin
            chk("busy", int'(busy), 1);
            chk("done", int'(done), (cyc == exp_done) ? 1 : 0);
        end else begin
            chk("busy_after", int'(busy), 0);
            chk("done_after", int'(done), 0);
            chk("events_left", ev.size() - ev_rd, 0);
            active = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (active) begin
            cyc++;
            check_cycle();
        end
    endtask

    task automatic init_ram();
        ram_init = 1'b1;
        tick();
        ram_init = 1'b0;
    endtask

    task automatic run(input logic [23:0] key, input int perturb_at, input int reset_at);
        secret_key = key;
        start      = 1'b1;
        cyc        = 0;
        ev_rd      = 0;
        done_cyc   = -1;
        active     = 1'b1;
        tick();
        start = 1'b0;
        for (int g = 0; g < 3000 && active; g++) begin
            if (cyc == perturb_at) begin
                start      = 1'b1;
                secret_key = ~key;
            end else begin
                start = 1'b0;
            end
            if (cyc == reset_at) begin
                restart = 1'b0;
                active  = 1'b0;
                tick();
                chk("abort_wren", int'(wren), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_address", int'(address), 0);
                chk("abort_data", int'(data), 0);
                chk("abort_done", int'(done), 0);
                restart = 1'b1;
            end else begin
                tick();
            end
        end
        start = 1'b0;
        if (active) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: still running at cycle %0d, required done by %0d", cyc, exp_done);
            active = 1'b0;
        end else if (reset_at < 0) begin
            chk("done_cycle", done_cyc, SKIP ? exp_done : 2049);
            for (int a = 0; a < 256; a++) chk($sformatf("ram[%0d]", a), int'(mem[a]), int'(exp_s[a]));
        end
    endtask

    initial begin
        bit   f;
        ev_t  e;
        restart    = 1'b0;
        start      = 1'b0;
        secret_key = 24'h0;
        tick();
        tick();
        chk("reset_address", int'(address), 0);
        chk("reset_data", int'(data), 0);
        chk("reset_wren", int'(wren), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        restart = 1'b1;
        tick();
        chk("idle_busy", int'(busy), 0);

        // Zero key: i=0 and i=1 are self-swaps, first real swap is i=2 with j=3.
        init_ram();
        build_model(24'h000000);
        find_ev(6, f, e);
        chk("pin_zero_i0_write", int'(f), SKIP ? 0 : 1);
        find_ev(SKIP ? 5 : 9, f, e);
        chk("pin_zero_rd_i1", e.addr, 1);
        find_ev(SKIP ? 9 : 17, f, e);
        chk("pin_zero_rd_i2", e.addr, 2);
        find_ev(SKIP ? 14 : 22, f, e);
        chk("pin_zero_wr1_addr", e.addr, 2);
        chk("pin_zero_wr1_data", e.data, 3);
        find_ev(SKIP ? 15 : 23, f, e);
        chk("pin_zero_wr2_addr", e.addr, 3);
        chk("pin_zero_wr2_data", e.data, 2);
        run(24'h000000, -1, -1);

        // Key 010203: i=0 gives j=1, i=1 gives j=3.
        init_ram();
        build_model(24'h010203);
        find_ev(6, f, e);
        chk("pin_k1_wr0_addr", e.addr, 0);
        chk("pin_k1_wr0_data", e.data, 1);
        find_ev(7, f, e);
        chk("pin_k1_wr1_addr", e.addr, 1);
        chk("pin_k1_wr1_data", e.data, 0);
        find_ev(12, f, e);
        chk("pin_k1_rd_j_i1", e.addr, 3);
        run(24'h010203, -1, -1);

        init_ram();
        build_model(24'h000249);
        run(24'h000249, -1, -1);

        // Stray start and key change mid-run must not disturb the schedule.
        init_ram();
        build_model(24'h000249);
        run(24'h000249, 500, -1);

        // Reset mid-run, then a clean rerun from i=0.
        init_ram();
        build_model(24'h000249);
        run(24'h000249, -1, 1000);
        tick();
        init_ram();
        build_model(24'h010203);
        run(24'h010203, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ksa_swap_fsm.md
# ksa_swap_fsm

Key-scheduling stage of the RC4 datapath. It runs after the S-array initialisation stage has written S[k] = k for k = 0..255 into the 256×8 on-chip RAM. It then performs the 256-iteration RC4 key-scheduling swap loop in place in that RAM: j = j + S[i] + key[i mod KEY_BYTES], followed by swapping S[i] and S[j]. It owns the RAM port for the whole run and reports completion with a one-cycle `done` pulse to the downstream PRGA stage.

## Interface
- `KEY_BYTES`, default 3: secret key length in bytes.
- `clock`  in  1: sole clock, rising edge.
- `restart`  in  1: synchronous, active-low reset.
- `start`  in  1: begin the schedule; sampled only in IDLE.
- `secret_key`  in  8*KEY_BYTES: key. Byte 0 is the most-significant byte.
- `q`  in  8: RAM read data.
- `address`  out  8: RAM address.
- `data`  out  8: RAM write data.
- `wren`  out  1: RAM write enable.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle completion pulse.

## Operation
- RAM model: the address is registered at the rising edge. `q` is valid during the cycle after the address is presented and is captured at the end of that cycle.
- Registers:
  - `i` (8 bits) and `j` (8 bits), both with modulo-256 wrap.
  - Key index `k`, range 0..KEY_BYTES-1. It is incremented with wrap alongside `i`; no divider.
  - `s_i` and `s_j` (8 bits each).
  - `key_q`, loaded from `secret_key` when `start` is accepted. Changes to `secret_key` during a run are ignored.
- States and transitions:
  - IDLE: `start`=1 → RD_I, with i=j=k=0 and the key latched.
  - RD_I: address=i → WAIT_I.
  - WAIT_I: s_i ← q → CALC_J.
  - CALC_J: j ← j + s_i + key_q[k] (8-bit truncating add) → RD_J.
  - RD_J: address=j → WAIT_J.
  - WAIT_J: s_j ← q → WR_I.
  - WR_I: address=i, data=s_j, wren=1 → WR_J.
  - WR_J: address=j, data=s_i, wren=1 → INC.
  - INC: if i==255 → DONE; else i++, k++ (with wrap) → RD_I.
  - DONE: `done`=1 → IDLE.
- Outside write states: `wren`=0 and `data`=0. `address`=0 in IDLE, DONE, CALC_J and INC.
- When i==j, both writes still occur (same address, same value) unless `KSA_SKIP_SELF_SWAP_EN` is defined.
- `start` outside IDLE is ignored. `start` held high through DONE causes a new run to begin one cycle after returning to IDLE.

## Timing
- Reset (`restart`=0 at a rising edge): state=IDLE, i=j=k=0, and address=0, data=0, wren=0, busy=0, done=0.
- Reset mid-run aborts immediately with no further writes. RAM contents are then unspecified and the init stage must rerun.
- `start` sampled at edge 0 → RD_I is cycle 1.
- Each iteration is 8 cycles.
- DONE is cycle 2049. `done` is high for exactly that cycle and `busy` drops in cycle 2050.
- At most one write per cycle, and no read and write in the same cycle.

## Configuration
- `KSA_SKIP_SELF_SWAP_EN` defined:
  - In CALC_J, the FSM compares the new j value (computed combinationally) with i. If they are equal it goes directly to INC, skipping RD_J, WAIT_J, WR_I and WR_J.
  - That iteration takes 4 cycles. Final RAM contents are identical to the undefined case.
- `KSA_SKIP_SELF_SWAP_EN` undefined: every iteration takes 8 cycles, giving the fixed 2049-cycle latency.

## Structure
- Package `ksa_pkg` holds:
  - the `ksa_state_t` enum;
  - `KSA_STEPS` = 256;
  - `KSA_ADDR_W` = 8;
  - the default `KEY_BYTES`.
- One sub-module, `ksa_key_sel`: a combinational byte mux returning `key_q[k]` with byte 0 as the MSB. All sequencing stays in the top module.

## Test plan
- **Zero key:** RAM preloaded with S[k]=k, key 24'h000000. The first distinct-address swap occurs at i=2, j=3: write addr 2 data 3, then addr 3 data 2. Without the macro, i=0 writes addr 0 data 0 twice.
- **First-iteration swap:** key 24'h010203, iteration i=0. Required: j=1, write addr 0 data 1 then addr 1 data 0. At i=1, j = 1+0+2 = 3.
- **Full run:** key 24'h000249. The final 256 RAM bytes match a software RC4 KSA model. `done` asserts in cycle 2049 and is high for exactly one cycle.
- **Ignored start and key change:** pulse `start` and change `secret_key` at cycle 500. Required: no restart of the run, and the result is unchanged from the full-run case.
- **Reset mid-run:** `restart`=0 at cycle 1000. Next cycle: wren=0, busy=0, address=0. A subsequent `start` reruns from i=0.
- **Macro defined:** rerun the zero-key case with the macro defined. Required: the i=0 and i=1 iterations take 4 cycles each with no writes, and the final RAM contents are identical to the undefined build.
